// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types for the GPR file,
// the forwarding unit and the ID/EX register.
package pipe_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/gpr_read_port.sv
// One combinational GPR read port.
// Optionally bypasses the write-back value.
module gpr_read_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              byp_en_i,
  input  logic [ADDR_W-1:0] byp_addr_i,
  input  logic [DATA_W-1:0] byp_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic hit;

  assign hit = BYPASS && byp_en_i &&
               (addr_i == byp_addr_i);

  always_comb begin
    data_o = word_i;
    if (addr_i == '0) begin
      data_o = '0;
    end else if (hit) begin
      data_o = byp_data_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: WB mux, 32-entry GPR file with
// WB->ID bypass, forwarding outputs, retired-write counter.
module wb_regfile #(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int ADDR_W = pipe_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] memrdatain,
  input  logic [DATA_W-1:0] ALUresultin,
  input  logic [ADDR_W-1:0] rt_rddin,
  input  logic              MemtoRegin,
  input  logic              Regwritein,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_rd,
  output logic              wb_valid,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_count
);

  import pipe_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              byp_en;

  assign wb_data  = MemtoRegin ? memrdatain : ALUresultin;
  assign wb_valid = Regwritein &&
                    (rt_rddin != ADDR_W'(REG_ZERO));
  assign wb_rd    = wb_valid ? rt_rddin : '0;

  // Bypass is masked in reset so every port reads the cleared array.
  assign byp_en = wb_valid && !rst;

  assign wr_count_d = wb_valid ? wr_count_q + 32'd1
                               : wr_count_q;
  assign wr_count   = wr_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else begin
      if (wb_valid) begin
        regs_q[rt_rddin] <= wb_data;
      end
      wr_count_q <= wr_count_d;
    end
  end

  gpr_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_rs (
    .addr_i     (rs_addr),
    .word_i     (regs_q[rs_addr]),
    .byp_en_i   (byp_en),
    .byp_addr_i (rt_rddin),
    .byp_data_i (wb_data),
    .data_o     (rs_data)
  );

  gpr_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_rt (
    .addr_i     (rt_addr),
    .word_i     (regs_q[rt_addr]),
    .byp_en_i   (byp_en),
    .byp_addr_i (rt_rddin),
    .byp_data_i (wb_data),
    .data_o     (rt_data)
  );

  // Debug port shows the raw array only.
  gpr_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
  ) u_dbg (
    .addr_i     (dbg_addr),
    .word_i     (regs_q[dbg_addr]),
    .byp_en_i   (1'b0),
    .byp_addr_i (rt_rddin),
    .byp_data_i (wb_data),
    .data_o     (dbg_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one bypassing and
// one non-bypassing instance share the same stimulus.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] memrdatain = '0;
  logic [31:0] ALUresultin = '0;
  logic [4:0]  rt_rddin = '0;
  logic        MemtoRegin = 1'b0;
  logic        Regwritein = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [4:0]  dbg_addr = '0;

  logic [31:0] rs_data, rt_data, wb_data, dbg_data, wr_count;
  logic [4:0]  wb_rd;
  logic        wb_valid;
  logic [31:0] rs_data0, rt_data0, wb_data0, dbg_data0, wr_count0;
  logic [4:0]  wb_rd0;
  logic        wb_valid0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .memrdatain(memrdatain), .ALUresultin(ALUresultin),
    .rt_rddin(rt_rddin), .MemtoRegin(MemtoRegin),
    .Regwritein(Regwritein),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_valid(wb_valid),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  wb_regfile #(.BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .memrdatain(memrdatain), .ALUresultin(ALUresultin),
    .rt_rddin(rt_rddin), .MemtoRegin(MemtoRegin),
    .Regwritein(Regwritein),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data0), .rt_data(rt_data0),
    .wb_data(wb_data0), .wb_rd(wb_rd0), .wb_valid(wb_valid0),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data0),
    .wr_count(wr_count0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_wr(input logic [4:0] rd,
                          input logic [31:0] alu,
                          input logic [31:0] mem,
                          input logic m2r,
                          input logic we);
    rt_rddin    = rd;
    ALUresultin = alu;
    memrdatain  = mem;
    MemtoRegin  = m2r;
    Regwritein  = we;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_count", wr_count, 32'h0);
    chk("rst_rs_data", rs_data, 32'h0);
    rst = 1'b0;

    // write r5 = 0x1234
    drive_wr(5'd5, 32'h1234, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    Regwritein = 1'b0;
    rs_addr = 5'd5;
    #1;
    chk("r5_write", rs_data, 32'h1234);
    chk("r5_count", wr_count, 32'd1);

    // async reset mid-cycle, no clock edge
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rs5", rs_data, 32'h0);
    chk("async_rst_count", wr_count, 32'h0);
    chk("async_rst_rs5_nb", rs_data0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_rs5", rs_data, 32'h0);

    // same-cycle bypass of r8
    @(negedge clk);
    drive_wr(5'd8, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
    rs_addr = 5'd8;
    dbg_addr = 5'd8;
    #1;
    chk("byp_rs8", rs_data, 32'hDEADBEEF);
    chk("nobyp_rs8_old", rs_data0, 32'h0);
    chk("byp_dbg8_raw", dbg_data, 32'h0);
    chk("byp_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("byp_wb_rd", {27'b0, wb_rd}, 32'd8);
    @(posedge clk);
    #1;
    chk("nobyp_rs8_new", rs_data0, 32'hDEADBEEF);
    chk("dbg8_new", dbg_data, 32'hDEADBEEF);
    @(negedge clk);
    Regwritein = 1'b0;
    #1;
    chk("r8_count", wr_count, 32'd1);

    // load data selected by MemtoReg
    drive_wr(5'd3, 32'h1, 32'hCAFEF00D, 1'b1, 1'b1);
    #1;
    chk("m2r_wb_data", wb_data, 32'hCAFEF00D);
    @(negedge clk);
    Regwritein = 1'b0;
    rt_addr = 5'd3;
    dbg_addr = 5'd3;
    #1;
    chk("m2r_rt3", rt_data, 32'hCAFEF00D);
    chk("m2r_dbg3", dbg_data, 32'hCAFEF00D);
    chk("m2r_rt3_nb", rt_data0, 32'hCAFEF00D);
    chk("m2r_count", wr_count, 32'd2);

    // write to r0 is dropped
    drive_wr(5'd0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    dbg_addr = 5'd0;
    #1;
    chk("r0_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("r0_wb_rd", {27'b0, wb_rd}, 32'd0);
    chk("r0_rs", rs_data, 32'h0);
    chk("r0_rt", rt_data, 32'h0);
    @(negedge clk);
    Regwritein = 1'b0;
    #1;
    chk("r0_rs_after", rs_data, 32'h0);
    chk("r0_dbg_after", dbg_data, 32'h0);
    chk("r0_count", wr_count, 32'd2);

    // Regwrite=0 leaves r9 alone
    drive_wr(5'd9, 32'h99, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive_wr(5'd9, 32'h5555, 32'h0, 1'b0, 1'b0);
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    #1;
    chk("nowe_rs9", rs_data, 32'h99);
    chk("nowe_rt9", rt_data, 32'h99);
    chk("nowe_wb_rd", {27'b0, wb_rd}, 32'd0);
    @(negedge clk);
    #1;
    chk("nowe_rs9_after", rs_data, 32'h99);
    chk("nowe_count", wr_count, 32'd3);

    // reset held with a pending write, then released
    rst = 1'b1;
    drive_wr(5'd10, 32'hA, 32'h0, 1'b0, 1'b1);
    rs_addr = 5'd10;
    #1;
    chk("rst_byp_gated", rs_data, 32'h0);
    chk("rst_rs9_clear", rt_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    Regwritein = 1'b0;
    #1;
    chk("rel_r10", rs_data, 32'hA);
    chk("rel_count", wr_count, 32'd1);

    // counter wrap
    @(negedge clk);
    force dut.wr_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wr_count_q;
    #1;
    chk("wrap_preload", wr_count, 32'hFFFFFFFF);
    drive_wr(5'd11, 32'h11, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    Regwritein = 1'b0;
    #1;
    chk("wrap_count", wr_count, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
